// File: rtl/priority_encoder_stream.sv
// Streaming priority encoder: accepts a multi-hot vector and emits
// the index of each set bit, lowest first, one per output handshake.
module priority_encoder_stream #(
  parameter int num_bits = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2**num_bits-1:0] in_vector,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [num_bits-1:0]   out_index,
  output logic                  out_last,
  output logic                  out_none,
  output logic                  busy
);

  localparam int W = 2**num_bits;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [W-1:0]        pending;
  logic [W-1:0]        pending_low_clr;
  logic [num_bits-1:0] low_idx;

  assign pending_low_clr = pending & (pending - W'(1));

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = DRAIN;
      DRAIN:   if (out_ready && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // pending bits: load on accept, drop lowest bit on each output beat
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending <= '0;
    end else if (state == IDLE && in_valid) begin
      pending <= in_vector;
    end else if (state == DRAIN && out_ready) begin
      pending <= pending_low_clr;
    end
  end

  // lowest set bit of pending; scanning downward leaves the lowest hit
  always_comb begin
    low_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = i[num_bits-1:0];
    end
  end

  // outputs from registered state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    out_index = out_valid ? low_idx : '0;
    out_last  = out_valid && (pending_low_clr == '0);
    out_none  = out_valid && (pending == '0);
  end

endmodule
